sample_fifo: RTL and testbench
==============================

# sample_fifo

Single-clock, parametrised sample FIFO for the FIR filter datapath, generalising the existing 16-bit dual-clock FIFO. Width, depth and almost-full/almost-empty thresholds are configurable. It adds an occupancy count, a registered read-valid strobe, sticky overflow/underflow flags, and a synchronous flush. It sits between the sample source and the filter core when both run on the same clock.

## Interface
- DATA_W, 16, sample width in bits
- DEPTH, 16, number of entries; power of two, ≥ 2
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH; 1 ≤ AF_THRESH ≤ DEPTH
- AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH; 0 ≤ AE_THRESH < DEPTH

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous empty request
- err_clr  in  1  clears overflow/underflow
- wr_data  in  DATA_W  write word
- wr_en  in  1  write request
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AF_THRESH
- rd_en  in  1  read request
- rd_data  out  DATA_W  registered read word
- rd_valid  out  1  rd_data updated this cycle
- empty  out  1  count == 0
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Storage: DEPTH×DATA_W array, write/read pointers of $clog2(DEPTH) bits. Pointers wrap DEPTH-1 → 0 naturally.
- Priority per edge: rst > flush > normal.
- rst: pointers = 0, count = 0, rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0. Outputs then read empty = 1, almost_empty = 1, full = 0, almost_full = 0. Array contents are don't-care.
- flush (rst low): pointers = 0, count = 0, rd_valid = 0.
  - rd_data holds its value; overflow and underflow hold.
  - wr_en and rd_en are ignored that cycle and set no flags.
- Normal cycle:
  - wr_acc = wr_en & (!full | rd_en).
  - rd_acc = rd_en & !empty.
  - wr_acc: mem[wptr] ← wr_data; wptr+1.
  - rd_acc: rd_data ← mem[rptr]; rptr+1; rd_valid ← 1. Otherwise rd_valid ← 0 and rd_data holds.
  - count ← count + wr_acc − rd_acc.
- Full with wr_en & rd_en: both accepted, count stays DEPTH. The read returns the oldest word, never the word being written.
- Empty with wr_en & rd_en: write accepted, read rejected, count becomes 1, underflow set.
- overflow ← 1 when wr_en & full & !rd_en.
- underflow ← 1 when rd_en & empty.
- err_clr clears both flags. A set and a clear in the same cycle resolve to set.
- Status outputs (full, empty, almost_*) are combinational decodes of the registered count only. They have no dependence on same-cycle inputs.

## Timing
- Write latency: word written at edge N is readable by rd_en in cycle N+1. empty deasserts in cycle N+1.
- Read latency: rd_en accepted at edge N gives rd_data and rd_valid = 1 in cycle N+1 (one cycle).
- Status flags and count change in the cycle after the accepting edge.
- Throughput: one write and one read per cycle sustained, at any occupancy.
- rst or flush asserted mid-stream takes effect at that edge; in-flight data is discarded.

## Test plan
- Reset, then check outputs (DATA_W=16, DEPTH=8, AF_THRESH=6, AE_THRESH=1): after rst, count = 0, empty = 1, almost_empty = 1, full = 0, rd_data = 0, flags = 0.
- Fill: write 1..8 on consecutive cycles.
  - almost_empty drops at count = 2.
  - almost_full rises at count = 6; full = 1 at count = 8.
  - A 9th write sets overflow and leaves count at 8.
- Drain: read 8 times; rd_data = 1..8 in order, rd_valid = 1 for each. Then empty = 1; a further read sets underflow and rd_data holds 8.
- Wrap and simultaneous access: 20 cycles of concurrent write/read at count = 4 keep count = 4 and preserve order across pointer wrap. The same test at count = 8 keeps count = 8 with no overflow.
- Flush and clear: flush at count = 5 with wr_en = rd_en = 1 gives count = 0, no flag change, and rd_data held. err_clr then clears overflow and underflow. err_clr coincident with a rejected read keeps underflow = 1.
- Mid-stream reset: rst during streaming at count = 3 gives every output its reset value on the next cycle.

Source files
------------

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO with occupancy count, registered read strobe,
// sticky overflow/underflow flags and a synchronous flush.
module sample_fifo #(
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       err_clr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       wr_en,
   output logic                       full,
   output logic                       almost_full,
   input  logic                       rd_en,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       rd_valid,
   output logic                       empty,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr, rptr;
   logic              wr_acc, rd_acc, ovf_set, udf_set, normal;

   // Status is a pure decode of the registered count.
   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   // A write into a full FIFO is legal when a read frees the slot this edge.
   assign normal  = ~rst & ~flush;
   assign wr_acc  = normal & wr_en & (~full | rd_en);
   assign rd_acc  = normal & rd_en & ~empty;
   assign ovf_set = wr_en & full & ~rd_en;
   assign udf_set = rd_en & empty;

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (wr_acc) wptr <= wptr + AW'(1);
         // Nonblocking read of mem returns the oldest word even when the
         // write pointer aliases the read pointer at full.
         if (rd_acc) begin
            rptr    <= rptr + AW'(1);
            rd_data <= mem[rptr];
         end
         rd_valid  <= rd_acc;
         count     <= count + CW'(wr_acc) - CW'(rd_acc);
         overflow  <= (overflow & ~err_clr) | ovf_set;
         underflow <= (underflow & ~err_clr) | udf_set;
      end
   end
endmodule

// File: tb/tb_sample_fifo.sv
// Randomised and directed bench for sample_fifo against a queue-based model.
module tb_sample_fifo;
   localparam int DW = 16, DEPTH = 8, AF = 6, AE = 1;

   logic          clk = 1'b0;
   logic          rst, flush, err_clr, wr_en, rd_en;
   logic [DW-1:0] wr_data;
   logic          full, almost_full, rd_valid, empty, almost_empty, overflow, underflow;
   logic [DW-1:0] rd_data;
   logic [3:0]    count;

   int n_tests = 0, n_fail = 0;

   logic [DW-1:0] q[$];
   logic [DW-1:0] m_rd;
   bit            m_vld, m_ovf, m_udf;

   sample_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
      .clk(clk), .rst(rst), .flush(flush), .err_clr(err_clr),
      .wr_data(wr_data), .wr_en(wr_en), .full(full), .almost_full(almost_full),
      .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
      .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      int n = q.size();
      chk({tag, ".count"}, 32'(count), 32'(n));
      chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
      chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
      chk({tag, ".af"}, 32'(almost_full), 32'(n >= AF));
      chk({tag, ".ae"}, 32'(almost_empty), 32'(n <= AE));
      chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_vld));
      chk({tag, ".rd_data"}, 32'(rd_data), 32'(m_rd));
      chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
      chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
   endtask

   // One clock: apply inputs, advance the model by the FIFO rules, check after the edge.
   task automatic step(input string tag, input bit w, input logic [DW-1:0] d,
                       input bit r, input bit f, input bit c, input bit rs);
      bit isfull, isempty, wacc, racc;
      rst = rs; flush = f; err_clr = c; wr_en = w; rd_en = r; wr_data = d;
      if (rs) begin
         q.delete(); m_rd = '0; m_vld = 0; m_ovf = 0; m_udf = 0;
      end else if (f) begin
         q.delete(); m_vld = 0;
      end else begin
         isfull  = (q.size() == DEPTH);
         isempty = (q.size() == 0);
         wacc = w && (!isfull || r);
         racc = r && !isempty;
         if (racc) m_rd = q.pop_front();
         m_vld = racc;
         if (wacc) q.push_back(d);
         m_ovf = (m_ovf && !c) || (w && isfull && !r);
         m_udf = (m_udf && !c) || (r && isempty);
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [DW-1:0] v;
      rst = 1; flush = 0; err_clr = 0; wr_en = 0; rd_en = 0; wr_data = '0;
      step("reset", 0, 0, 0, 0, 0, 1);
      step("reset2", 1, 16'h55, 1, 0, 0, 1);
      chk("reset.rd_data0", 32'(rd_data), 32'h0);

      for (int i = 1; i <= 8; i++) step("fill", 1, DW'(i), 0, 0, 0, 0);
      chk("fill.full", 32'(full), 32'h1);
      step("fill9", 1, 16'd9, 0, 0, 0, 0);
      chk("fill9.count", 32'(count), 32'd8);
      chk("fill9.ovf", 32'(overflow), 32'h1);

      for (int i = 1; i <= 8; i++) begin
         step("drain", 0, 0, 1, 0, 0, 0);
         chk("drain.value", 32'(rd_data), 32'(i));
      end
      step("drain_udf", 0, 0, 1, 0, 0, 0);
      chk("drain_udf.hold", 32'(rd_data), 32'd8);

      step("clr", 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) step("pre4", 1, DW'($urandom), 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) step("wrap4", 1, DW'($urandom), 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step("pre8", 1, DW'($urandom), 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) step("wrap8", 1, DW'($urandom), 1, 0, 0, 0);
      chk("wrap8.noovf", 32'(overflow), 32'h0);

      for (int i = 0; i < 3; i++) step("to5", 0, 0, 1, 0, 0, 0);
      v = rd_data;
      step("flush", 1, 16'hBEEF, 1, 1, 0, 0);
      chk("flush.hold", 32'(rd_data), 32'(v));
      step("mk_udf", 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 9; i++) step("mk_ovf", 1, DW'($urandom), 0, 0, 0, 0);
      step("clr_both", 0, 0, 0, 0, 1, 0);
      step("empty_wr_rd", 1, 16'h1234, 1, 1, 0, 0);
      step("empty_wr_rd2", 1, 16'h1234, 1, 0, 0, 0);
      step("drain1", 0, 0, 1, 0, 0, 0);
      step("clr_vs_set", 0, 0, 1, 0, 1, 0);
      chk("clr_vs_set.udf", 32'(underflow), 32'h1);

      for (int i = 0; i < 3; i++) step("to3", 1, DW'($urandom), 0, 0, 0, 0);
      step("mid_rst", 1, 16'hAAAA, 1, 0, 0, 1);
      chk("mid_rst.count", 32'(count), 32'h0);

      for (int i = 0; i < 600; i++) begin
         step("rand", ($urandom_range(0, 99) < 60), DW'($urandom),
              ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 3),
              ($urandom_range(0, 99) < 5), ($urandom_range(0, 199) < 1));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
